// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: field/immediate decode, operand read with same-cycle
// write-back bypass, load-use hazard detection, and the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic [6:0]  ex_funct7,
    output logic        ex_reg_write,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_illegal
);

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtBad
    } fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        reg_write;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } idex_t;

    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpSystem = 7'h73;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpJal    = 7'h6F;

    // Raw instruction fields
    logic [6:0] opcode;
    logic [4:0] rd_f;
    logic [2:0] funct3;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [6:0] funct7;

    assign opcode = if_instr[6:0];
    assign rd_f   = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1_f  = if_instr[19:15];
    assign rs2_f  = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    assign rf_a1 = rs1_f;
    assign rf_a2 = rs2_f;

    fmt_e        fmt;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        uses_rd;
    logic        reg_write;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [31:0] imm;

    always_comb begin
        fmt = FmtBad;
        unique case (opcode)
            OpReg:                            fmt = FmtR;
            OpImm, OpLoad, OpJalr, OpSystem:  fmt = FmtI;
            OpStore:                          fmt = FmtS;
            OpBranch:                         fmt = FmtB;
            OpLui, OpAuipc:                   fmt = FmtU;
            OpJal:                            fmt = FmtJ;
            default:                          fmt = FmtBad;
        endcase
    end

    always_comb begin
        uses_rs1 = (fmt == FmtR) || (fmt == FmtI) || (fmt == FmtS) || (fmt == FmtB);
        uses_rs2 = (fmt == FmtR) || (fmt == FmtS) || (fmt == FmtB);
        uses_rd  = (fmt == FmtR) || (fmt == FmtI) || (fmt == FmtU) || (fmt == FmtJ);
        reg_write = uses_rd && (rd_f != 5'd0);
        rs1_idx  = uses_rs1 ? rs1_f : 5'd0;
        rs2_idx  = uses_rs2 ? rs2_f : 5'd0;
        rd_idx   = uses_rd  ? rd_f  : 5'd0;
    end

    always_comb begin
        imm = 32'd0;
        unique case (fmt)
            FmtI: imm = {{20{if_instr[31]}}, if_instr[31:20]};
            FmtS: imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            FmtB: imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                         if_instr[11:8], 1'b0};
            FmtU: imm = {if_instr[31:12], 12'd0};
            FmtJ: imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                         if_instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    // Index 0 reads as zero; a same-cycle write-back wins over the stale file value.
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        if (rs1_idx == 5'd0) begin
            rs1_val = 32'd0;
        end else if (wb_we && (wb_rd == rs1_idx)) begin
            rs1_val = wb_data;
        end else begin
            rs1_val = rf_rd1;
        end

        if (rs2_idx == 5'd0) begin
            rs2_val = 32'd0;
        end else if (wb_we && (wb_rd == rs2_idx)) begin
            rs2_val = wb_data;
        end else begin
            rs2_val = rf_rd2;
        end
    end

    idex_t idex_q, idex_d;
    logic  valid_q, valid_d;
    logic  hazard;

    always_comb begin
        hazard = valid_q && idex_q.is_load && (idex_q.rd != 5'd0) &&
                 ((uses_rs1 && (rs1_idx == idex_q.rd)) ||
                  (uses_rs2 && (rs2_idx == idex_q.rd)));
        id_ready = (!valid_q || ex_ready) && !hazard;
    end

    always_comb begin
        idex_d  = idex_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (if_valid && id_ready) begin
            valid_d           = 1'b1;
            idex_d.pc         = if_pc;
            idex_d.rs1_val    = rs1_val;
            idex_d.rs2_val    = rs2_val;
            idex_d.imm        = imm;
            idex_d.rs1        = rs1_idx;
            idex_d.rs2        = rs2_idx;
            idex_d.rd         = rd_idx;
            idex_d.opcode     = opcode;
            idex_d.funct3     = funct3;
            idex_d.funct7     = funct7;
            idex_d.reg_write  = reg_write;
            idex_d.is_load    = (opcode == OpLoad);
            idex_d.is_store   = (opcode == OpStore);
            idex_d.illegal    = (fmt == FmtBad);
        end else if (ex_ready) begin
            // Drained with nothing accepted: insert a bubble.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idex_q  <= idex_d;
            valid_q <= valid_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = idex_q.pc;
    assign ex_rs1_val   = idex_q.rs1_val;
    assign ex_rs2_val   = idex_q.rs2_val;
    assign ex_imm       = idex_q.imm;
    assign ex_rs1       = idex_q.rs1;
    assign ex_rs2       = idex_q.rs2;
    assign ex_rd        = idex_q.rd;
    assign ex_opcode    = idex_q.opcode;
    assign ex_funct3    = idex_q.funct3;
    assign ex_funct7    = idex_q.funct7;
    assign ex_reg_write = idex_q.reg_write;
    assign ex_is_load   = idex_q.is_load;
    assign ex_is_store  = idex_q.is_store;
    assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, bypass, load-use bubble, stall, flush, reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_reg_write, ex_is_load, ex_is_store, ex_illegal;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .rf_a1        (rf_a1),
        .rf_a2        (rf_a2),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_val   (ex_rs1_val),
        .ex_rs2_val   (ex_rs2_val),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_opcode    (ex_opcode),
        .ex_funct3    (ex_funct3),
        .ex_funct7    (ex_funct7),
        .ex_reg_write (ex_reg_write),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_illegal   (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'd0;
        if_pc    = 32'd0;
        rf_rd1   = 32'd0;
        rf_rd2   = 32'd0;
        wb_we    = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        flush    = 1'b0;
        ex_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // addi x1,x0,5: rf value for x0 must be ignored
        if_valid = 1'b1;
        if_instr = 32'h0050_0093;
        if_pc    = 32'h100;
        rf_rd1   = 32'h77;
        step();
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_rd", {27'd0, ex_rd}, 32'd1);
        chk("addi_rs1", {27'd0, ex_rs1}, 32'd0);
        chk("addi_rs1_val", ex_rs1_val, 32'd0);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_reg_write", {31'd0, ex_reg_write}, 32'd1);
        chk("addi_opcode", {25'd0, ex_opcode}, 32'h13);
        chk("addi_pc", ex_pc, 32'h100);

        // sw x5,-4(x6)
        if_instr = 32'hFE53_2E23;
        if_pc    = 32'h104;
        rf_rd1   = 32'h60;
        rf_rd2   = 32'h50;
        #1;
        chk("sw_rf_a1", {27'd0, rf_a1}, 32'd6);
        chk("sw_rf_a2", {27'd0, rf_a2}, 32'd5);
        step();
        chk("sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("sw_rs1", {27'd0, ex_rs1}, 32'd6);
        chk("sw_rs2", {27'd0, ex_rs2}, 32'd5);
        chk("sw_rd", {27'd0, ex_rd}, 32'd0);
        chk("sw_is_store", {31'd0, ex_is_store}, 32'd1);
        chk("sw_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("sw_rs1_val", ex_rs1_val, 32'h60);
        chk("sw_rs2_val", ex_rs2_val, 32'h50);
        chk("sw_funct3", {29'd0, ex_funct3}, 32'd2);

        // lw x2,0(x1)
        if_instr = 32'h0000_A103;
        if_pc    = 32'h108;
        rf_rd1   = 32'h11;
        step();
        chk("lw_is_load", {31'd0, ex_is_load}, 32'd1);
        chk("lw_rd", {27'd0, ex_rd}, 32'd2);
        chk("lw_rs1_val", ex_rs1_val, 32'h11);

        // add x3,x2,x1 right behind the load, with write-back of x2 in flight
        if_instr = 32'h0011_01B3;
        if_pc    = 32'h10C;
        rf_rd1   = 32'hDEAD;
        rf_rd2   = 32'h5;
        wb_we    = 1'b1;
        wb_rd    = 5'd2;
        wb_data  = 32'h1234;
        #1;
        chk("hz_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        chk("hz_bubble", {31'd0, ex_valid}, 32'd0);
        chk("hz_ready_again", {31'd0, id_ready}, 32'd1);
        step();
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_pc", ex_pc, 32'h10C);
        chk("add_rs1_val_bypass", ex_rs1_val, 32'h1234);
        chk("add_rs2_val", ex_rs2_val, 32'h5);
        chk("add_rd", {27'd0, ex_rd}, 32'd3);
        chk("add_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // Stall for three cycles with a new word pending
        wb_we    = 1'b0;
        ex_ready = 1'b0;
        if_instr = 32'h0050_0093;
        if_pc    = 32'h110;
        rf_rd1   = 32'hBEEF;
        #1;
        chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_pc", ex_pc, 32'h10C);
            chk("stall_rs1_val", ex_rs1_val, 32'h1234);
            chk("stall_rd", {27'd0, ex_rd}, 32'd3);
            chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
        end

        // Flush with if_valid high and ex_ready low: word dropped, ID/EX emptied
        flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0;

        // Refill and stall, then reset asynchronously mid-cycle
        step();
        chk("refill_valid", {31'd0, ex_valid}, 32'd1);
        chk("refill_pc", ex_pc, 32'h110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_imm", ex_imm, 32'd0);
        chk("arst_rd", {27'd0, ex_rd}, 32'd0);
        chk("arst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_id_ready", {31'd0, id_ready}, 32'd1);

        // Illegal opcode
        ex_ready = 1'b1;
        if_instr = 32'h0000_007F;
        if_pc    = 32'h200;
        step();
        chk("ill_valid", {31'd0, ex_valid}, 32'd1);
        chk("ill_illegal", {31'd0, ex_illegal}, 32'd1);
        chk("ill_reg_write", {31'd0, ex_reg_write}, 32'd0);

        // jal x1,8
        if_instr = 32'h0080_00EF;
        if_pc    = 32'h204;
        step();
        chk("jal_imm", ex_imm, 32'd8);
        chk("jal_rd", {27'd0, ex_rd}, 32'd1);
        chk("jal_illegal", {31'd0, ex_illegal}, 32'd0);

        // lui x0,0x12345: U immediate, rd=0 never writes
        if_instr = 32'h1234_5037;
        if_pc    = 32'h208;
        step();
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_reg_write", {31'd0, ex_reg_write}, 32'd0);

        // Nothing offered, execute drains: bubble
        if_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, ex_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
